// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit.
// One radix-2 step per cycle on operand magnitudes, then a single fixup cycle
// for sign correction and the divide special cases, so every operation takes
// exactly DATA_WIDTH+2 cycles from acceptance to the Done pulse.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   Start, Kill       - begin an operation (IDLE only) / abort one in flight
//   SrcA, SrcB        - multiplicand/dividend, multiplier/divisor
//   Operation         - RV32M funct3 (MUL..REMU)
//   Busy, Done        - in-flight flag, one-cycle result-valid pulse
//   MDUResult         - result of the last completed operation
module mdu_seq #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     Start,
  input  logic                     Kill,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     Busy,
  output logic                     Done,
  output logic [DATA_WIDTH-1:0]    MDUResult
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [OPCODE_LENGTH-1:0] r_op;
  logic [W-1:0]             r_a;      // multiplicand or divisor magnitude
  logic [W-1:0]             r_hi;     // partial product high / running remainder
  logic [W-1:0]             r_lo;     // multiplier bits / dividend -> quotient bits
  logic [W-1:0]             r_srca;   // raw dividend, returned on divide by zero
  logic                     r_a_neg;
  logic                     r_b_neg;
  logic                     r_b_zero;
  logic                     r_ovf;

  // Operand decode at acceptance: which operands are interpreted as signed
  logic         w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_is_div;
  logic [W-1:0] w_a_mag, w_b_mag;

  always_comb begin
    w_is_div   = Operation[2];
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (Operation[2:0])
      3'b001:         begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      3'b010:         begin w_a_signed = 1'b1; end
      3'b100, 3'b110: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      default:        ;
    endcase
    w_a_neg = w_a_signed & SrcA[W-1];
    w_b_neg = w_b_signed & SrcB[W-1];
    w_a_mag = w_a_neg ? -SrcA : SrcA;
    w_b_mag = w_b_neg ? -SrcB : SrcB;
  end

  // One iteration: shift-add for multiply, restoring subtract-shift for divide
  logic [W:0] w_mul_sum, w_div_sh, w_div_sub;
  logic       w_div_ge;

  always_comb begin
    w_mul_sum = {1'b0, r_hi} + ({1'b0, r_a} & {(W+1){r_lo[0]}});
    w_div_sh  = {r_hi, r_lo[W-1]};
    w_div_ge  = (w_div_sh >= {1'b0, r_a});
    w_div_sub = w_div_sh - {1'b0, r_a};
  end

  // Sign correction and special cases; r_lo holds the quotient, r_hi the remainder
  logic [2*W-1:0] w_prod, w_prod_s;
  logic [W-1:0]   w_quo, w_rem, w_result;

  always_comb begin
    w_prod   = {r_hi, r_lo};
    w_prod_s = (r_a_neg ^ r_b_neg) ? -w_prod : w_prod;
    w_quo    = (r_a_neg ^ r_b_neg) ? -r_lo : r_lo;
    w_rem    = r_a_neg ? -r_hi : r_hi;
    w_result = '0;
    case (r_op[2:0])
      3'b000:                 w_result = w_prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: w_result = w_prod_s[2*W-1:W];
      3'b100:  w_result = r_b_zero ? '1 : (r_ovf ? r_srca : w_quo);
      3'b101:  w_result = r_b_zero ? '1 : r_lo;
      3'b110:  w_result = r_b_zero ? r_srca : (r_ovf ? '0 : w_rem);
      default: w_result = r_b_zero ? r_srca : r_hi;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_srca    <= '0;
      r_a_neg   <= 1'b0;
      r_b_neg   <= 1'b0;
      r_b_zero  <= 1'b0;
      r_ovf     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      MDUResult <= '0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Kill wins over a simultaneous Start
          if (Start && !Kill) begin
            r_op     <= Operation;
            r_a      <= w_is_div ? w_b_mag : w_a_mag;
            r_hi     <= '0;
            r_lo     <= w_is_div ? w_a_mag : w_b_mag;
            r_srca   <= SrcA;
            r_a_neg  <= w_a_neg;
            r_b_neg  <= w_b_neg;
            r_b_zero <= (SrcB == '0);
            r_ovf    <= w_is_div && !Operation[0] && (SrcA == MOST_NEG) && (SrcB == '1);
            r_cnt    <= '0;
            r_state  <= S_CALC;
            Busy     <= 1'b1;
          end
        end
        S_CALC: begin
          if (Kill) begin
            r_state <= S_IDLE;
            Busy    <= 1'b0;
          end else begin
            if (r_op[2]) begin
              r_hi <= w_div_ge ? w_div_sub[W-1:0] : w_div_sh[W-1:0];
              r_lo <= {r_lo[W-2:0], w_div_ge};
            end else begin
              r_hi <= w_mul_sum[W:1];
              r_lo <= {w_mul_sum[0], r_lo[W-1:1]};
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(W-1)) r_state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          if (Kill) begin
            r_state <= S_IDLE;
            Busy    <= 1'b0;
          end else begin
            MDUResult <= w_result;
            r_state   <= S_DONE;
            Busy      <= 1'b0;
            Done      <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed RV32M corner cases, restart/kill/reset
// disturbances and randomized operations against a plain-arithmetic reference.
module tb_mdu_seq;

  localparam int unsigned LAT = 34;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic        Kill;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  Operation;
  logic        Busy;
  logic        Done;
  logic [31:0] MDUResult;

  int          n_chk;
  int          n_err;
  logic [31:0] last_res;

  mdu_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .Kill      (Kill),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation),
    .Busy      (Busy),
    .Done      (Done),
    .MDUResult (MDUResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics with 64-bit integer arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb, ps;
    longint unsigned ua, ub, pu;
    logic [31:0]     res;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    case (op)
      3'd0: begin pu = ua * ub; res = pu[31:0]; end
      3'd1: begin ps = sa * sb; res = ps[63:32]; end
      3'd2: begin ps = sa * longint'(ub); res = ps[63:32]; end
      3'd3: begin pu = ua * ub; res = pu[63:32]; end
      3'd4: begin
        if (b == 0) res = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
        else begin ps = sa / sb; res = ps[31:0]; end
      end
      3'd5: begin
        if (b == 0) res = 32'hFFFF_FFFF;
        else begin pu = ua / ub; res = pu[31:0]; end
      end
      3'd6: begin
        if (b == 0) res = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = '0;
        else begin ps = sa % sb; res = ps[31:0]; end
      end
      default: begin
        if (b == 0) res = a;
        else begin pu = ua % ub; res = pu[31:0]; end
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic watch_no_done(input string tag);
    int ndone;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (Done) ndone++;
    end
    check({tag, "_nodone"}, ndone, 0);
  endtask

  // Issue one operation; optional Start retrigger, Kill or reset at a given CALC cycle (0 = none)
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag,
                        input int restart_at, input int kill_at, input int rst_at);
    int cyc;
    @(negedge clk);
    Operation = op; SrcA = a; SrcB = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    SrcA = $urandom; SrcB = $urandom; Operation = 3'($urandom);
    check({tag, "_busy"}, Busy, 1);
    cyc = 1;
    while (!Done && cyc < 100) begin
      if (cyc == restart_at) begin
        Start = 1'b1; SrcA = $urandom; SrcB = $urandom;
      end
      if (cyc == kill_at) Kill = 1'b1;
      if (cyc == rst_at) begin
        rst_n = 1'b0; #1;
        check({tag, "_rst_busy"}, Busy, 0);
        check({tag, "_rst_done"}, Done, 0);
        check({tag, "_rst_res"}, MDUResult, 0);
        last_res = '0;
        @(negedge clk); rst_n = 1'b1;
        watch_no_done(tag);
        return;
      end
      @(posedge clk); #1;
      Start = 1'b0; Kill = 1'b0;
      cyc++;
      if (kill_at != 0 && cyc == kill_at + 1) begin
        check({tag, "_kill_busy"}, Busy, 0);
        check({tag, "_kill_done"}, Done, 0);
        check({tag, "_kill_res"}, MDUResult, last_res);
        watch_no_done(tag);
        check({tag, "_kill_hold"}, MDUResult, last_res);
        return;
      end
    end
    check({tag, "_lat"}, cyc, LAT);
    check(tag, MDUResult, exp);
    check({tag, "_busy_done"}, Busy, 0);
    last_res = exp;
    @(posedge clk); #1;
    check({tag, "_pulse"}, Done, 0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    n_chk = 0; n_err = 0; last_res = '0;
    rst_n = 1'b0; Start = 1'b0; Kill = 1'b0;
    SrcA = '0; SrcB = '0; Operation = '0;
    #3;
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_res", MDUResult, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases with hand-derived results
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3", 0, 0, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max", 0, 0, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min", 0, 0, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "mulhsu_m1", 0, 0, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2", 0, 0, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2", 0, 0, 0);
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0", 0, 0, 0);
    run_op(3'd7, 32'd5, 32'd0, 32'd5, "remu_by0", 0, 0, 0);
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by0", 0, 0, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "rem_by0", 0, 0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf", 0, 0, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf", 0, 0, 0);

    // Result holds in IDLE, and Kill in IDLE does nothing
    @(negedge clk); Kill = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_kill_busy", Busy, 0);
    check("idle_kill_res", MDUResult, 32'd0);
    @(negedge clk); Kill = 1'b0;

    // Restart ignored mid-operation, then kill, then a fresh accepted op
    run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, ref_mdu(3'd3, 32'h1234_5678, 32'h9ABC_DEF0),
           "restart", 10, 0, 0);
    run_op(3'd5, 32'd1000, 32'd7, 32'd0, "kill20", 0, 20, 0);
    run_op(3'd5, 32'd1000, 32'd7, 32'd142, "after_kill", 0, 0, 0);

    // Reset in the middle of a divide, then first Start after release
    run_op(3'd4, 32'd100, 32'd3, 32'd0, "rst15", 0, 0, 15);
    run_op(3'd0, 32'd6, 32'd7, 32'd42, "after_rst", 0, 0, 0);

    // Randomized operations against the reference
    for (int i = 0; i < 160; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = rnd_val();
      b  = rnd_val();
      run_op(op, a, b, ref_mdu(op, a, b), $sformatf("rnd%0d_op%0d", i, op), 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter OPCODE_LENGTH, default 3, giving the Operation width (RV32M funct3).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port Start, input, 1 bit: request to begin an operation.
REQ-006 The block SHALL have port Kill, input, 1 bit: synchronous abort of an in-flight operation.
REQ-007 The block SHALL have port SrcA, input, DATA_WIDTH bits: multiplicand or dividend.
REQ-008 The block SHALL have port SrcB, input, DATA_WIDTH bits: multiplier or divisor.
REQ-009 The block SHALL have port Operation, input, OPCODE_LENGTH bits: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-010 The block SHALL have port Busy, output, 1 bit: high while an operation is in flight.
REQ-011 The block SHALL have port Done, output, 1 bit: single-cycle pulse marking a valid result.
REQ-012 The block SHALL have port MDUResult, output, DATA_WIDTH bits: the result of the last completed operation.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIXUP and DONE.
REQ-014 In IDLE, Start=1 SHALL register SrcA, SrcB and Operation, clear the iteration counter and move to CALC on the next edge.
REQ-015 Start SHALL be ignored in every state other than IDLE, and operand changes after acceptance SHALL have no effect.
REQ-016 CALC SHALL run exactly DATA_WIDTH cycles, one radix-2 step per cycle (shift-add for multiply, restoring subtract-shift for divide), on operand magnitudes; it then SHALL go to FIXUP.
REQ-017 FIXUP SHALL last 1 cycle: apply sign correction, handle the special cases, load MDUResult, then go to DONE.
REQ-018 DONE SHALL last 1 cycle with Done=1, then return to IDLE.
REQ-019 Latency SHALL be fixed at DATA_WIDTH+2 cycles from the accepting edge to the Done cycle (34 for the default), independent of operand values.
REQ-020 Busy SHALL be 1 in CALC and FIXUP and 0 in IDLE and DONE.
REQ-021 MUL SHALL return the low DATA_WIDTH bits of the product; MULH, MULHSU and MULHU SHALL return the high DATA_WIDTH bits of the 2*DATA_WIDTH product, treating the operands as signed x signed, signed x unsigned and unsigned x unsigned respectively.
REQ-022 DIV and REM SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-023 Divide by zero SHALL return quotient all-ones for DIV and DIVU, and SrcA for REM and REMU.
REQ-024 Signed overflow (SrcA = most-negative, SrcB = all-ones) SHALL return quotient SrcA for DIV and 0 for REM.
REQ-025 The cases in REQ-023 and REQ-024 SHALL still take the full latency of REQ-019.
REQ-026 Kill=1 in CALC or FIXUP SHALL return the FSM to IDLE on the next edge, with no Done and MDUResult unchanged.
REQ-027 Kill=1 in IDLE or DONE SHALL have no effect, and Kill takes priority over Start in the same cycle.
REQ-028 MDUResult SHALL hold its value from FIXUP until the next FIXUP.

Reset
REQ-029 rst_n=0 SHALL immediately force the FSM to IDLE and set Busy=0, Done=0, MDUResult=0, and clear the counter and internal registers, including mid-operation.
REQ-030 After rst_n deasserts, the first Start in IDLE SHALL be accepted on the next rising edge.

Verification
REQ-031 MUL with SrcA=7, SrcB=0xFFFFFFFD -> Done in cycle 34, MDUResult=0xFFFFFFEB; MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 MULH with SrcA=SrcB=0x80000000 -> 0x40000000; MULHSU with SrcA=0xFFFFFFFF, SrcB=2 -> 0xFFFFFFFF.
REQ-033 DIV with SrcA=0xFFFFFFF9 (-7), SrcB=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-034 DIVU with SrcA=5, SrcB=0 -> 0xFFFFFFFF; REMU with SrcA=5, SrcB=0 -> 5; DIV with SrcA=0x80000000, SrcB=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; each Done exactly 34 cycles after acceptance.
REQ-035 Start pulsed again at cycle 10 of a running operation -> ignored, and the first result is still delivered; Kill at cycle 20 -> Busy=0 on the next cycle, no Done, MDUResult keeps its previous value, and a new Start is then accepted.
REQ-036 rst_n asserted at cycle 15 of a DIV -> Busy=0, Done=0 and MDUResult=0 immediately, and no Done follows after release.
